fifo_fill_ctrl: RTL and testbench

- Upstream feeder for the 16-in/32-out line FIFO.
- Fetches a block of 16-bit words from the SDRAM controller in bursts, honouring FIFO occupancy, and pushes each returned word into the FIFO write port.
- Runs in the FIFO write-clock domain; the FIFO's 32-bit read side is consumed by the display/DMA logic.

---
 rtl/fifo_fill_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_fifo_fill_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_fill_ctrl.sv
// fifo_fill_ctrl: fetches a block of 16-bit words from the SDRAM controller
// in bursts of up to BURST words, one burst outstanding at a time, and pushes
// every returned word into the line FIFO write port (fifo wrclk domain).
// A new burst is requested only while the FIFO has room for a whole burst.
//
// Optional feature macro: FIFO_FILL_PAD_EN
//   defined   -> odd block lengths get one trailing 0x0000 word so the 32-bit
//                FIFO read side always sees complete word pairs.
//   undefined -> exactly word_count words are written.
//
// Handshakes:
//   mem_req/mem_ack : mem_req is the valid, mem_ack the ready. A burst is
//                     taken on a clock edge where both are 1; mem_addr and
//                     mem_len are stable while mem_req is 1, and once raised
//                     mem_req stays up until taken (only abort withdraws it).
//   mem_dv          : one data word per cycle with mem_dv=1, no backpressure.
//   fifo_wrreq      : one word written per cycle with fifo_wrreq=1; the FIFO
//                     never stalls us because requests are gated on occupancy.
module fifo_fill_ctrl #(
    parameter int ADDR_W     = 21,
    parameter int LEN_W      = 16,
    parameter int BURST      = 8,
    parameter int HIGH_WATER = 448
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_len,
    input  logic              mem_ack,
    input  logic              mem_dv,
    input  logic [15:0]       mem_din,
    output logic [15:0]       fifo_data,
    output logic              fifo_wrreq,
    input  logic [8:0]        fifo_wrusedw
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_XFER  = 3'd2,
        S_DRAIN = 3'd3,
        S_PAD   = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] addr;       // next burst start address
    logic [LEN_W-1:0]  rem;        // words not yet requested
    logic [3:0]        beats;      // data beats still owed by the current burst
    logic              req_hold;   // mem_req was up last cycle and not yet taken

    logic [3:0]        cur_len;
    logic [31:0]       fill_sum;
    logic              room;
    logic              start_take;
    logic              ack_taken;
    logic              beat_dv;
    logic              beat_write;
    logic              pad_needed;
    logic              pad_write;

`ifdef FIFO_FILL_PAD_EN
    logic              pad_pend;   // latched block length was odd
`endif

    // Burst length is the smaller of BURST and the words still to request.
    always_comb begin
        cur_len = rem[3:0];
        if (rem >= LEN_W'(BURST)) begin
            cur_len = 4'(BURST);
        end
    end

    // FIFO room test done at 32 bits so the sum cannot wrap.
    always_comb begin
        fill_sum = 32'(fifo_wrusedw) + 32'(BURST);
        room     = (fill_sum <= 32'(HIGH_WATER));
    end

    // Once raised, the request is held regardless of later occupancy changes.
    assign mem_req    = (state == S_REQ) && !abort && (req_hold || room);
    assign mem_addr   = addr;
    assign mem_len    = cur_len;
    assign ack_taken  = mem_req && mem_ack;
    assign start_take = (state == S_IDLE) && start && !abort;
    assign beat_dv    = mem_dv && (beats != 4'd0) && ((state == S_XFER) || (state == S_DRAIN));
    assign beat_write = beat_dv && (state == S_XFER) && !abort;
    assign busy       = (state == S_REQ) || (state == S_XFER) || (state == S_DRAIN) || (state == S_PAD);
    assign done       = (state == S_FIN);

`ifdef FIFO_FILL_PAD_EN
    assign pad_needed = pad_pend;
`else
    assign pad_needed = 1'b0;
`endif

    // The pad word is queued in the cycle after the last data write.
    assign pad_write = (state == S_XFER) && !abort && (beats == 4'd0) && (rem == '0) && pad_needed;

    // State register.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; XFER waits one cycle after the last beat so done
    // lands one cycle after the final FIFO write.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_take) begin
                    state_nxt = (word_count == '0) ? S_FIN : S_REQ;
                end
            end
            S_REQ: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (ack_taken) begin
                    state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                if (abort) begin
                    state_nxt = S_DRAIN;
                end else if (beats == 4'd0) begin
                    if (rem != '0) begin
                        state_nxt = S_REQ;
                    end else if (pad_needed) begin
                        state_nxt = S_PAD;
                    end else begin
                        state_nxt = S_FIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((beats == 4'd0) || (beat_dv && (beats == 4'd1))) begin
                    state_nxt = S_IDLE;
                end
            end
            S_PAD: begin
                state_nxt = S_FIN;
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Request hold flag: remembers an untaken request across cycles.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            req_hold <= 1'b0;
        end else begin
            req_hold <= mem_req && !mem_ack;
        end
    end

    // Address/remaining/beat counters and the registered FIFO write port.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            addr       <= '0;
            rem        <= '0;
            beats      <= 4'd0;
            fifo_data  <= 16'h0000;
            fifo_wrreq <= 1'b0;
        end else begin
            fifo_wrreq <= beat_write || pad_write;
            if (beat_write) begin
                fifo_data <= mem_din;
            end else if (pad_write) begin
                fifo_data <= 16'h0000;
            end
            if (start_take) begin
                addr <= base_addr;
                rem  <= word_count;
            end else if (ack_taken) begin
                addr <= addr + ADDR_W'(cur_len);
                rem  <= rem - LEN_W'(cur_len);
            end
            if (ack_taken) begin
                beats <= cur_len;
            end else if (beat_dv) begin
                beats <= beats - 4'd1;
            end
        end
    end

`ifdef FIFO_FILL_PAD_EN
    // Odd-length flag captured with the block parameters.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            pad_pend <= 1'b0;
        end else if (start_take) begin
            pad_pend <= word_count[0];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Testbench for fifo_fill_ctrl: randomized memory responder, a burst/word
// reference model built from the block rules, and a write scoreboard.
module tb_fifo_fill_ctrl;

    logic        clk = 1'b0;
    logic        aclr;
    logic        start;
    logic        abort;
    logic [20:0] base_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic        mem_req;
    logic [20:0] mem_addr;
    logic [3:0]  mem_len;
    logic        mem_ack;
    logic        mem_dv;
    logic [15:0] mem_din;
    logic [15:0] fifo_data;
    logic        fifo_wrreq;
    logic [8:0]  fifo_wrusedw;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_wr_cyc = 0;
    bit          rand_used = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];

    fifo_fill_ctrl #(
        .ADDR_W(21), .LEN_W(16), .BURST(8), .HIGH_WATER(448)
    ) dut (
        .clk(clk), .aclr(aclr), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .done(done),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_ack(mem_ack), .mem_dv(mem_dv), .mem_din(mem_din),
        .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .fifo_wrusedw(fifo_wrusedw)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: collect FIFO writes and done pulses away from the active edge.
    always @(negedge clk) begin
        if (fifo_wrreq) begin
            obs_q.push_back(fifo_data);
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    // Watchdog against a hung DUT.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; inputs change 1ns after the edge, sampling 2ns after.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_used) fifo_wrusedw = 9'($urandom_range(0, 449));
        #1;
    endtask

    task automatic wait_req(input string name, output bit ok);
        int n = 0;
        while (!mem_req && n < 200) begin
            tick();
            n++;
        end
        ok = mem_req;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_req_timeout: got mem_req=%b want 1 within 200 cycles", name, mem_req);
        end
    endtask

    // Full block: start, serve every burst, compare against the model.
    task automatic run_block(input logic [20:0] base, input logic [15:0] count,
                             input int hold, input bit glitch, input string name);
        logic [20:0] m_addr;
        int          m_rem;
        int          exp_len;
        int          n;
        bit          ok;
        bit          seen;
        bit          first;
        exp_q.delete();
        obs_q.delete();
        done_cnt = 0;
        m_addr = base;
        m_rem  = int'(count);
        first  = 1'b1;
        start = 1'b1; base_addr = base; word_count = count;
        tick();
        start = 1'b0; base_addr = 21'($urandom); word_count = 16'($urandom);
        if (hold > 0) begin
            seen = 1'b0;
            for (int i = 0; i < hold; i++) begin
                if (mem_req) seen = 1'b1;
                tick();
            end
            checks++;
            if (seen !== 1'b0) begin
                errors++;
                $display("FAIL %s_high_water: got mem_req=1 above high water, want 0", name);
            end
            fifo_wrusedw = 9'd440;
            #1;
        end
        while (m_rem != 0) begin
            wait_req(name, ok);
            if (!ok) break;
            exp_len = (m_rem > 8) ? 8 : m_rem;
            n = $urandom_range(0, 2);
            for (int d = 0; d < n; d++) begin
                checks++;
                if (mem_req !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_req_held: got mem_req=%b want 1", name, mem_req);
                end
                tick();
            end
            checks++;
            if (mem_addr !== m_addr) begin
                errors++;
                $display("FAIL %s_mem_addr: got %h want %h", name, mem_addr, m_addr);
            end
            checks++;
            if (mem_len !== 4'(exp_len)) begin
                errors++;
                $display("FAIL %s_mem_len: got %0d want %0d", name, mem_len, exp_len);
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            checks++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL %s_req_drop: got mem_req=%b want 0", name, mem_req);
            end
            m_addr = m_addr + 21'(exp_len);
            m_rem  = m_rem - exp_len;
            for (int b = 0; b < exp_len; b++) begin
                n = $urandom_range(0, 2);
                for (int g = 0; g < n; g++) tick();
                mem_dv  = 1'b1;
                mem_din = 16'($urandom);
                exp_q.push_back(mem_din);
                if (glitch && first) begin
                    start = 1'b1; base_addr = 21'h0ABCD; word_count = 16'd3;
                end
                first = 1'b0;
                tick();
                mem_dv = 1'b0;
                start  = 1'b0;
            end
        end
`ifdef FIFO_FILL_PAD_EN
        if (count[0]) exp_q.push_back(16'h0000);
`endif
        n = 0;
        while (done_cnt == 0 && n < 30) begin
            tick();
            n++;
        end
        repeat (3) tick();
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL %s_done_count: got %0d want 1", name, done_cnt);
        end
        if (count != 16'd0) begin
            checks++;
            if (done_cyc !== last_wr_cyc + 1) begin
                errors++;
                $display("FAIL %s_done_timing: got done at cycle %0d want %0d", name, done_cyc, last_wr_cyc + 1);
            end
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_write_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_data[%0d]: got %h want %h", name, i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_end: got %b want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        aclr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_addr !== 21'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_len !== 4'h0) begin errors++; $display("FAIL reset_mem_len: got %h want 0", mem_len); end
        checks++; if (fifo_wrreq !== 1'b0) begin errors++; $display("FAIL reset_wrreq: got %b want 0", fifo_wrreq); end
        checks++; if (fifo_data !== 16'h0) begin errors++; $display("FAIL reset_fifo_data: got %h want 0", fifo_data); end
        @(negedge clk);
        aclr = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        fifo_wrusedw = 9'd0;
        run_block(21'h01000, 16'd16, 0, 1'b0, "basic");
    endtask

    task automatic test_high_water();
        fifo_wrusedw = 9'd441;
        run_block(21'h00200, 16'd5, 10, 1'b0, "high_water");
        fifo_wrusedw = 9'd0;
    endtask

    task automatic test_abort_xfer();
        bit ok;
        obs_q.delete();
        exp_q.delete();
        done_cnt = 0;
        start = 1'b1; base_addr = 21'h00400; word_count = 16'd8;
        tick();
        start = 1'b0;
        wait_req("abort_xfer", ok);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_dv = 1'b1; mem_din = 16'($urandom); exp_q.push_back(mem_din);
            tick();
            mem_dv = 1'b0;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL abort_xfer_busy_drain: got %b want 1", busy); end
            end
            mem_dv = 1'b1; mem_din = 16'($urandom);
            tick();
            mem_dv = 1'b0;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_xfer_busy_end: got %b want 0", busy); end
        mem_dv = 1'b1; mem_din = 16'hDEAD;
        tick();
        mem_dv = 1'b0;
        repeat (3) tick();
        checks++;
        if (obs_q.size() !== 3) begin errors++; $display("FAIL abort_xfer_writes: got %0d want 3", obs_q.size()); end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_xfer_data[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL abort_xfer_done: got %0d want 0", done_cnt); end
    endtask

    task automatic test_abort_ack();
        bit ok;
        obs_q.delete();
        done_cnt = 0;
        start = 1'b1; base_addr = 21'h00800; word_count = 16'd8;
        tick();
        start = 1'b0;
        wait_req("abort_ack", ok);
        mem_ack = 1'b1;
        abort   = 1'b1;
        tick();
        mem_ack = 1'b0;
        abort   = 1'b0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL abort_ack_req: got %b want 0", mem_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_ack_busy: got %b want 0", busy); end
        for (int i = 0; i < 3; i++) begin
            mem_dv = 1'b1; mem_din = 16'($urandom);
            tick();
            mem_dv = 1'b0;
        end
        repeat (3) tick();
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL abort_ack_writes: got %0d want 0", obs_q.size()); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_ack_done: got %0d want 0", done_cnt); end
        // start and abort together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1; base_addr = 21'h00900; word_count = 16'd4;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy: got %b want 0", busy); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL start_abort_req: got %b want 0", mem_req); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        start = 1'b1; base_addr = 21'h01200; word_count = 16'd16;
        tick();
        start = 1'b0;
        wait_req("reset_mid", ok);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_dv = 1'b1; mem_din = 16'($urandom);
            tick();
            mem_dv = 1'b0;
        end
        mem_dv = 1'b1; mem_din = 16'h1234;
        @(posedge clk);
        #3;
        aclr = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mid_req: got %b want 0", mem_req); end
        checks++; if (fifo_wrreq !== 1'b0) begin errors++; $display("FAIL reset_mid_wrreq: got %b want 0", fifo_wrreq); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_mid_done: got %b want 0", done); end
        mem_dv = 1'b0;
        @(negedge clk);
        aclr = 1'b1;
        tick();
        run_block(21'h00040, 16'd2, 0, 1'b0, "after_reset");
    endtask

    task automatic test_zero();
        done_cnt = 0;
        start = 1'b1; base_addr = 21'h00010; word_count = 16'd0;
        tick();
        start = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL zero_req: got %b want 0", mem_req); end
        tick();
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_clear: got %b want 0", done); end
    endtask

    task automatic test_start_busy();
        run_block(21'h02000, 16'd12, 0, 1'b1, "start_busy");
    endtask

    task automatic test_odd();
        run_block(21'h03000, 16'd3, 0, 1'b0, "odd3");
    endtask

    task automatic test_random();
        logic [20:0] base;
        logic [15:0] count;
        rand_used = 1'b1;
        for (int b = 0; b < 6; b++) begin
            base  = (b == 0) ? 21'h1FFFFC : 21'($urandom);
            count = 16'($urandom_range(1, 40));
            run_block(base, count, 0, 1'b0, "random");
        end
        rand_used = 1'b0;
        fifo_wrusedw = 9'd0;
    endtask

    initial begin
        aclr = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = 21'h0; word_count = 16'h0;
        mem_ack = 1'b0; mem_dv = 1'b0; mem_din = 16'h0;
        fifo_wrusedw = 9'd0;
        test_reset();
        test_basic();
        test_high_water();
        test_abort_xfer();
        test_abort_ack();
        test_reset_mid();
        test_zero();
        test_start_busy();
        test_odd();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
